// File: rtl/uba_iack_arb.sv
// Interrupt request/acknowledge arbiter for four IO-bridge devices in two PI groups.
// Define UBA_IACK_NXD_EN to answer an unclaimed acknowledge with a zero vector and nxdO.
module uba_iack_arb #(
  parameter logic [3:0] UBANUM = 4'd1,
  parameter logic [8:0] VEC0   = 9'o254,
  parameter logic [8:0] VEC1   = 9'o224,
  parameter logic [8:0] VEC2   = 9'o230,
  parameter logic [8:0] VEC3   = 9'o264
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        devRESET,
  input  logic [3:0]  devIRQ,
  input  logic [2:0]  hiPIA,
  input  logic [2:0]  loPIA,
  input  logic        busIACK,
  input  logic [2:0]  busPI,
  output logic [6:0]  ubaINTR,
  output logic        ackVALID,
  output logic [17:0] ackVECT,
  output logic [3:0]  devIACK,
  output logic        nxdO
);

  localparam int unsigned NUM_LVL = 7;

  typedef enum logic [1:0] {IDLE, ARB, RESP, HOLD} state_t;

  state_t      state, state_nxt;
  logic [2:0]  pi_reg, pi_nxt;
  logic        last_iack;
  logic        hi_req, lo_req;
  logic [3:0]  eligible;
  logic        has_win;
  logic [1:0]  win_idx;
  logic [6:0]  intr_nxt;
  logic        ack_valid_nxt;
  logic [17:0] ack_vect_nxt;
  logic [3:0]  dev_iack_nxt;
  logic        nxd_nxt;

  function automatic logic [8:0] vec_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return VEC0;
      2'd1:    return VEC1;
      2'd2:    return VEC2;
      default: return VEC3;
    endcase
  endfunction

  assign hi_req = devIRQ[0] | devIRQ[1];
  assign lo_req = devIRQ[2] | devIRQ[3];

  // A device is eligible only if its group is programmed to the level being acknowledged.
  assign eligible[0] = devIRQ[0] & (hiPIA == pi_reg) & (pi_reg != 3'd0);
  assign eligible[1] = devIRQ[1] & (hiPIA == pi_reg) & (pi_reg != 3'd0);
  assign eligible[2] = devIRQ[2] & (loPIA == pi_reg) & (pi_reg != 3'd0);
  assign eligible[3] = devIRQ[3] & (loPIA == pi_reg) & (pi_reg != 3'd0);
  assign has_win     = |eligible;

  always_comb begin
    win_idx = 2'd3;
    if (eligible[2]) win_idx = 2'd2;
    if (eligible[1]) win_idx = 2'd1;
    if (eligible[0]) win_idx = 2'd0;
  end

  // Bit k-1 of ubaINTR represents PI level k; a PIA of zero matches no bit.
  always_comb begin
    intr_nxt = '0;
    for (int k = 0; k < int'(NUM_LVL); k++) begin
      intr_nxt[k] = (hi_req & (hiPIA == 3'(k + 1))) | (lo_req & (loPIA == 3'(k + 1)));
    end
  end

  // Response outputs are registered on the ARB->RESP edge so they are visible during RESP.
  always_comb begin
    state_nxt     = state;
    pi_nxt        = pi_reg;
    ack_valid_nxt = 1'b0;
    ack_vect_nxt  = '0;
    dev_iack_nxt  = '0;
    nxd_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (busIACK && !last_iack) begin
          pi_nxt    = busPI;
          state_nxt = ARB;
        end
      end
      ARB: begin
        if (has_win) begin
          state_nxt     = RESP;
          ack_valid_nxt = 1'b1;
          ack_vect_nxt  = {UBANUM, 5'b0, vec_of(win_idx)};
          dev_iack_nxt  = 4'(4'b0001 << win_idx);
        end else begin
`ifdef UBA_IACK_NXD_EN
          state_nxt     = RESP;
          ack_valid_nxt = 1'b1;
          ack_vect_nxt  = {UBANUM, 14'b0};
          nxd_nxt       = 1'b1;
`else
          state_nxt     = HOLD;
`endif
        end
      end
      RESP: state_nxt = HOLD;
      HOLD: begin
        if (!busIACK) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (devRESET) begin
      state_nxt     = IDLE;
      ack_valid_nxt = 1'b0;
      ack_vect_nxt  = '0;
      dev_iack_nxt  = '0;
      nxd_nxt       = 1'b0;
    end
  end

  // lastIACK resets high so an acknowledge held through reset is not taken as new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pi_reg    <= '0;
      last_iack <= 1'b1;
      ubaINTR   <= '0;
      ackVALID  <= 1'b0;
      ackVECT   <= '0;
      devIACK   <= '0;
      nxdO      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pi_reg    <= pi_nxt;
      last_iack <= busIACK;
      ubaINTR   <= devRESET ? 7'b0 : intr_nxt;
      ackVALID  <= ack_valid_nxt;
      ackVECT   <= ack_vect_nxt;
      devIACK   <= dev_iack_nxt;
      nxdO      <= nxd_nxt;
    end
  end

endmodule

// File: tb/tb_uba_iack_arb.sv
// Self-checking bench for uba_iack_arb: vector tables, corner sequences and randomized traffic.
module tb_uba_iack_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        devRESET;
  logic [3:0]  devIRQ;
  logic [2:0]  hiPIA, loPIA;
  logic        busIACK;
  logic [2:0]  busPI;
  logic [6:0]  ubaINTR;
  logic        ackVALID;
  logic [17:0] ackVECT;
  logic [3:0]  devIACK;
  logic        nxdO;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uba_iack_arb dut (
    .clk(clk), .rst(rst), .devRESET(devRESET), .devIRQ(devIRQ),
    .hiPIA(hiPIA), .loPIA(loPIA), .busIACK(busIACK), .busPI(busPI),
    .ubaINTR(ubaINTR), .ackVALID(ackVALID), .ackVECT(ackVECT),
    .devIACK(devIACK), .nxdO(nxdO)
  );

  typedef struct {
    logic [3:0] irq;
    logic [2:0] hi;
    logic [2:0] lo;
    logic [6:0] exp_intr;
  } intr_vec_t;

  typedef struct {
    logic [3:0]  irq;
    logic [2:0]  hi;
    logic [2:0]  lo;
    logic [2:0]  pi;
    logic [3:0]  exp_dev;
    logic [17:0] exp_vect;
  } ack_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Level k is requested when a requesting group is programmed to k.
  function automatic logic [6:0] model_intr(input logic [3:0] irq, input logic [2:0] hi,
                                            input logic [2:0] lo);
    logic [6:0] r;
    r = '0;
    for (int lvl = 1; lvl <= 7; lvl++) begin
      if ((irq[1:0] != 2'b00 && int'(hi) == lvl) || (irq[3:2] != 2'b00 && int'(lo) == lvl))
        r[lvl-1] = 1'b1;
    end
    return r;
  endfunction

  // Expected response to an acknowledge of level pi given the request state in ARB.
  task automatic model_ack(input logic [3:0] irq, input logic [2:0] hi, input logic [2:0] lo,
                           input logic [2:0] pi, output logic valid, output logic [17:0] vect,
                           output logic [3:0] dev, output logic nxd);
    int vecs[4];
    int found;
    vecs  = '{'o254, 'o224, 'o230, 'o264};
    found = -1;
    for (int n = 3; n >= 0; n--) begin
      int pia;
      pia = (n < 2) ? int'(hi) : int'(lo);
      if (irq[n] && pi != 3'd0 && pia == int'(pi)) found = n;
    end
    valid = 1'b0; vect = '0; dev = '0; nxd = 1'b0;
    if (found >= 0) begin
      valid = 1'b1;
      vect  = 18'(('o40000) + vecs[found]);
      dev   = 4'(1 << found);
    end else begin
`ifdef UBA_IACK_NXD_EN
      valid = 1'b1;
      vect  = 18'o040000;
      nxd   = 1'b1;
`endif
    end
  endtask

  // Full acknowledge handshake: ARB cycle, RESP cycle, hold, release.
  task automatic do_ack(input string nm, input logic [2:0] pi, input int hold, input logic drop,
                        output logic [3:0] got_dev, output logic [17:0] got_vect);
    logic        ev;
    logic [17:0] evect;
    logic [3:0]  edev;
    logic        enxd;
    busIACK = 1'b1;
    busPI   = pi;
    if (drop) devIRQ = 4'b0000;
    tick();
    chk({nm, " arb ackVALID"}, 32'(ackVALID), 32'(0));
    model_ack(devIRQ, hiPIA, loPIA, pi, ev, evect, edev, enxd);
    tick();
    got_dev  = devIACK;
    got_vect = ackVECT;
    chk({nm, " ackVALID"}, 32'(ackVALID), 32'(ev));
    chk({nm, " ackVECT"},  32'(ackVECT),  32'(evect));
    chk({nm, " devIACK"},  32'(devIACK),  32'(edev));
    chk({nm, " nxdO"},     32'(nxdO),     32'(enxd));
    for (int i = 0; i <= hold; i++) begin
      tick();
      chk({nm, " hold strobe"}, 32'({ackVALID, devIACK, nxdO}), 32'(0));
    end
    busIACK = 1'b0;
    tick();
  endtask

  intr_vec_t  itab[8];
  ack_vec_t   atab[6];
  logic [3:0]  gd;
  logic [17:0] gv;

  initial begin
    itab = '{
      '{4'b0001, 3'd5, 3'd0, 7'b0010000},
      '{4'b0100, 3'd5, 3'd3, 7'b0000100},
      '{4'b1010, 3'd6, 3'd6, 7'b0100000},
      '{4'b0011, 3'd0, 3'd2, 7'b0000000},
      '{4'b1100, 3'd1, 3'd7, 7'b1000000},
      '{4'b1111, 3'd1, 3'd2, 7'b0000011},
      '{4'b0000, 3'd3, 3'd4, 7'b0000000},
      '{4'b1000, 3'd0, 3'd0, 7'b0000000}
    };
    atab = '{
      '{4'b0001, 3'd5, 3'd0, 3'd5, 4'b0001, 18'o040254},
      '{4'b1110, 3'd6, 3'd6, 3'd6, 4'b0010, 18'o040224},
      '{4'b1100, 3'd6, 3'd6, 3'd6, 4'b0100, 18'o040230},
      '{4'b1000, 3'd2, 3'd3, 3'd3, 4'b1000, 18'o040264},
      '{4'b0110, 3'd4, 3'd4, 3'd4, 4'b0010, 18'o040224},
      '{4'b1111, 3'd7, 3'd1, 3'd1, 4'b0100, 18'o040230}
    };

    rst = 1'b1; devRESET = 1'b0; devIRQ = '0; hiPIA = '0; loPIA = '0;
    busIACK = 1'b0; busPI = '0;
    tick(); tick();
    chk("reset outputs", 32'({ubaINTR, ackVALID, ackVECT, devIACK, nxdO}), 32'(0));
    rst = 1'b0;
    tick();

    foreach (itab[i]) begin
      devIRQ = itab[i].irq; hiPIA = itab[i].hi; loPIA = itab[i].lo;
      tick();
      chk($sformatf("intr table %0d", i), 32'(ubaINTR), 32'(itab[i].exp_intr));
    end

    foreach (atab[i]) begin
      devIRQ = atab[i].irq; hiPIA = atab[i].hi; loPIA = atab[i].lo;
      tick();
      do_ack($sformatf("ack table %0d", i), atab[i].pi, 1, 1'b0, gd, gv);
      chk($sformatf("ack table %0d dev", i),  32'(gd), 32'(atab[i].exp_dev));
      chk($sformatf("ack table %0d vect", i), 32'(gv), 32'(atab[i].exp_vect));
    end

    // Long hold gives one strobe; re-acknowledge after the winner drops moves to the next device.
    devIRQ = 4'b1110; hiPIA = 3'd6; loPIA = 3'd6;
    tick();
    do_ack("hold5", 3'd6, 5, 1'b0, gd, gv);
    chk("hold5 dev", 32'(gd), 32'(4'b0010));
    devIRQ = 4'b1100;
    do_ack("rearm", 3'd6, 0, 1'b0, gd, gv);
    chk("rearm dev", 32'(gd), 32'(4'b0100));

    // Wrong level, PI zero and a request dropped at the edge all take the no-winner path.
    devIRQ = 4'b0001; hiPIA = 3'd4; loPIA = 3'd0;
    tick();
    do_ack("wrong level", 3'd3, 0, 1'b0, gd, gv);
    do_ack("pi zero", 3'd0, 0, 1'b0, gd, gv);
    devIRQ = 4'b0001;
    do_ack("drop at edge", 3'd4, 0, 1'b1, gd, gv);

    // Request dropped after ARB still receives its response.
    devIRQ = 4'b0001; hiPIA = 3'd5;
    tick();
    busIACK = 1'b1; busPI = 3'd5;
    tick();
    tick();
    devIRQ = 4'b0000;
    chk("late drop dev", 32'(devIACK), 32'(4'b0001));
    tick();
    busIACK = 1'b0;
    tick();

    // Async reset during ARB with the acknowledge held: no response until a fresh edge.
    devIRQ = 4'b0001; hiPIA = 3'd5;
    tick();
    busIACK = 1'b1; busPI = 3'd5;
    tick();
    rst = 1'b1;
    #1;
    chk("rst in arb outputs", 32'({ubaINTR, ackVALID, ackVECT, devIACK, nxdO}), 32'(0));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post rst no strobe", 32'({ackVALID, devIACK}), 32'(0));
    end
    busIACK = 1'b0;
    tick();
    do_ack("post rst fresh", 3'd5, 0, 1'b0, gd, gv);
    chk("post rst fresh dev", 32'(gd), 32'(4'b0001));

    // devRESET during ARB suppresses the response and clears ubaINTR.
    busIACK = 1'b1; busPI = 3'd5;
    tick();
    devRESET = 1'b1;
    tick();
    chk("devreset arb", 32'({ubaINTR, ackVALID, devIACK, nxdO}), 32'(0));
    devRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("devreset arb no strobe", 32'({ackVALID, devIACK}), 32'(0));
    end
    busIACK = 1'b0;
    tick();

    // devRESET during RESP: next cycle idle, nothing acknowledged, fresh edge works.
    busIACK = 1'b1;
    tick();
    tick();
    chk("resp strobe", 32'(devIACK), 32'(4'b0001));
    devRESET = 1'b1;
    tick();
    chk("devreset resp", 32'({ubaINTR, ackVALID, devIACK, nxdO}), 32'(0));
    devRESET = 1'b0;
    busIACK = 1'b0;
    tick();
    do_ack("after devreset", 3'd5, 0, 1'b0, gd, gv);
    chk("after devreset dev", 32'(gd), 32'(4'b0001));

    // Randomized traffic against the reference model.
    for (int it = 0; it < 150; it++) begin
      logic [2:0] pi;
      devIRQ = 4'($urandom_range(0, 15));
      hiPIA  = 3'($urandom_range(0, 7));
      loPIA  = 3'($urandom_range(0, 7));
      tick();
      chk($sformatf("rand intr %0d", it), 32'(ubaINTR), 32'(model_intr(devIRQ, hiPIA, loPIA)));
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0:       pi = hiPIA;
          1:       pi = loPIA;
          default: pi = 3'($urandom_range(0, 7));
        endcase
        do_ack($sformatf("rand ack %0d", it), pi, int'($urandom_range(0, 3)), 1'b0, gd, gv);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
